// File: rtl/pong_pkg.sv
// Shared definitions for the pong collision engine: controller states,
// wall_hit bit positions and hit_zone encodings.
package pong_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EVAL    = 2'd1,
        ST_RESOLVE = 2'd2,
        ST_SERVE   = 2'd3
    } engine_state_t;

    localparam int WALL_BOTTOM = 0;
    localparam int WALL_RIGHT  = 1;
    localparam int WALL_TOP    = 2;
    localparam int WALL_LEFT   = 3;

    localparam logic [1:0] ZONE_NONE   = 2'b00;
    localparam logic [1:0] ZONE_TOP    = 2'b01;
    localparam logic [1:0] ZONE_MIDDLE = 2'b10;
    localparam logic [1:0] ZONE_BOTTOM = 2'b11;

endpackage

// File: rtl/aabb_overlap.sv
// Axis-aligned rectangle overlap test; edges that merely touch count as overlap.
// Sums are one bit wider than the coordinates so they never wrap.
module aabb_overlap #(
    parameter int COORD_W = 11
) (
    input  logic [COORD_W-1:0] a_x,
    input  logic [COORD_W-1:0] a_y,
    input  logic [COORD_W-1:0] a_w,
    input  logic [COORD_W-1:0] a_h,
    input  logic [COORD_W-1:0] b_x,
    input  logic [COORD_W-1:0] b_y,
    input  logic [COORD_W-1:0] b_w,
    input  logic [COORD_W-1:0] b_h,
    output logic               overlap
);

    logic [COORD_W:0] a_right, a_bottom, b_right, b_bottom;

    assign a_right  = {1'b0, a_x} + {1'b0, a_w};
    assign a_bottom = {1'b0, a_y} + {1'b0, a_h};
    assign b_right  = {1'b0, b_x} + {1'b0, b_w};
    assign b_bottom = {1'b0, b_y} + {1'b0, b_h};

    assign overlap = (a_right >= {1'b0, b_x}) && ({1'b0, a_x} <= b_right) &&
                     (a_bottom >= {1'b0, b_y}) && ({1'b0, a_y} <= b_bottom);

endmodule

// File: rtl/collision_engine.sv
// Per-frame pong collision engine: latches the ball and paddles on frame_tick,
// evaluates walls and paddles, then resolves direction, scoring and serve hold.
module collision_engine
    import pong_pkg::*;
#(
    parameter int COORD_W      = 11,
    parameter int SCREEN_W     = 640,
    parameter int SCREEN_H     = 480,
    parameter int MARGIN       = 10,
    parameter int LOCK_FRAMES  = 4,
    parameter int SERVE_FRAMES = 60
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_tick,
    input  logic [COORD_W-1:0] ball_x,
    input  logic [COORD_W-1:0] ball_y,
    input  logic [COORD_W-1:0] ball_w,
    input  logic [COORD_W-1:0] ball_h,
    input  logic [COORD_W-1:0] padl_x,
    input  logic [COORD_W-1:0] padl_y,
    input  logic [COORD_W-1:0] padl_w,
    input  logic [COORD_W-1:0] padl_h,
    input  logic [COORD_W-1:0] padr_x,
    input  logic [COORD_W-1:0] padr_y,
    input  logic [COORD_W-1:0] padr_w,
    input  logic [COORD_W-1:0] padr_h,
    output logic [3:0]         wall_hit,
    output logic               dir_x,
    output logic               dir_y,
    output logic               hit_l,
    output logic               hit_r,
    output logic               score_l,
    output logic               score_r,
    output logic               bounce_y,
    output logic               evt_valid,
    output logic [1:0]         hit_zone,
    output logic               serve_hold,
    output logic               overrun
);

    localparam int LOCK_W  = $clog2(LOCK_FRAMES + 1);
    localparam int SERVE_W = $clog2(SERVE_FRAMES + 1);

    localparam logic [COORD_W:0] EDGE_LIM  = (COORD_W+1)'(MARGIN);
    localparam logic [COORD_W:0] RIGHT_LIM = (COORD_W+1)'(SCREEN_W - MARGIN);
    localparam logic [COORD_W:0] BOT_LIM   = (COORD_W+1)'(SCREEN_H - MARGIN);

    engine_state_t state;

    logic [COORD_W-1:0] b_x, b_y, b_w, b_h;
    logic [COORD_W-1:0] l_x, l_y, l_w, l_h;
    logic [COORD_W-1:0] r_x, r_y, r_w, r_h;

    logic               top_q, bot_q, left_q, right_q;
    logic               ovl_l_q, ovl_r_q;
    logic [1:0]         zone_l_q, zone_r_q;

    logic [LOCK_W-1:0]  lockout;
    logic [SERVE_W-1:0] serve_cnt;

    logic               ovl_l, ovl_r;
    logic [COORD_W:0]   ball_right, ball_bottom, centre;

    logic               take_l, take_r, any_hit, goal_l, goal_r;
    logic               next_dir_y, next_bounce;

    aabb_overlap #(.COORD_W(COORD_W)) u_overlap_l (
        .a_x(b_x), .a_y(b_y), .a_w(b_w), .a_h(b_h),
        .b_x(l_x), .b_y(l_y), .b_w(l_w), .b_h(l_h),
        .overlap(ovl_l)
    );

    aabb_overlap #(.COORD_W(COORD_W)) u_overlap_r (
        .a_x(b_x), .a_y(b_y), .a_w(b_w), .a_h(b_h),
        .b_x(r_x), .b_y(r_y), .b_w(r_w), .b_h(r_h),
        .overlap(ovl_r)
    );

    assign ball_right  = {1'b0, b_x} + {1'b0, b_w};
    assign ball_bottom = {1'b0, b_y} + {1'b0, b_h};
    assign centre      = {1'b0, b_y} + {2'b0, b_h[COORD_W-1:1]};

    // Quarter-height bands at each end of the paddle; everything between is middle.
    function automatic logic [1:0] zone_of(input logic [COORD_W:0]   c,
                                           input logic [COORD_W-1:0] py,
                                           input logic [COORD_W-1:0] ph);
        logic [COORD_W:0] quarter, top_lim, bot_lim;
        quarter = {3'b0, ph[COORD_W-1:2]};
        top_lim = {1'b0, py} + quarter;
        bot_lim = {1'b0, py} + {1'b0, ph} - quarter;
        if (c < top_lim)      return ZONE_TOP;
        else if (c > bot_lim) return ZONE_BOTTOM;
        else                  return ZONE_MIDDLE;
    endfunction

    always_comb begin
        take_r      = ovl_r_q && dir_x && (lockout == '0);
        take_l      = ovl_l_q && !dir_x && (lockout == '0);
        any_hit     = take_r || take_l;
        goal_r      = left_q && !any_hit;
        goal_l      = right_q && !any_hit && !left_q;
        next_dir_y  = dir_y;
        next_bounce = 1'b0;
        if (top_q && !bot_q && !dir_y) begin
            next_dir_y  = 1'b1;
            next_bounce = 1'b1;
        end else if (bot_q && !top_q && dir_y) begin
            next_dir_y  = 1'b0;
            next_bounce = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            wall_hit   <= '0;
            dir_x      <= 1'b1;
            dir_y      <= 1'b1;
            hit_l      <= 1'b0;
            hit_r      <= 1'b0;
            score_l    <= 1'b0;
            score_r    <= 1'b0;
            bounce_y   <= 1'b0;
            evt_valid  <= 1'b0;
            hit_zone   <= ZONE_NONE;
            serve_hold <= 1'b0;
            overrun    <= 1'b0;
            lockout    <= '0;
            serve_cnt  <= '0;
            b_x <= '0; b_y <= '0; b_w <= '0; b_h <= '0;
            l_x <= '0; l_y <= '0; l_w <= '0; l_h <= '0;
            r_x <= '0; r_y <= '0; r_w <= '0; r_h <= '0;
            top_q <= 1'b0; bot_q <= 1'b0; left_q <= 1'b0; right_q <= 1'b0;
            ovl_l_q <= 1'b0; ovl_r_q <= 1'b0;
            zone_l_q <= ZONE_NONE; zone_r_q <= ZONE_NONE;
        end else begin
            hit_l     <= 1'b0;
            hit_r     <= 1'b0;
            score_l   <= 1'b0;
            score_r   <= 1'b0;
            bounce_y  <= 1'b0;
            evt_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (frame_tick) begin
                        b_x <= ball_x; b_y <= ball_y; b_w <= ball_w; b_h <= ball_h;
                        l_x <= padl_x; l_y <= padl_y; l_w <= padl_w; l_h <= padl_h;
                        r_x <= padr_x; r_y <= padr_y; r_w <= padr_w; r_h <= padr_h;
                        state <= ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    if (frame_tick) overrun <= 1'b1;
                    top_q    <= {1'b0, b_y} <= EDGE_LIM;
                    bot_q    <= ball_bottom >= BOT_LIM;
                    left_q   <= {1'b0, b_x} <= EDGE_LIM;
                    right_q  <= ball_right >= RIGHT_LIM;
                    ovl_l_q  <= ovl_l;
                    ovl_r_q  <= ovl_r;
                    zone_l_q <= zone_of(centre, l_y, l_h);
                    zone_r_q <= zone_of(centre, r_y, r_h);
                    state    <= ST_RESOLVE;
                end
                ST_RESOLVE: begin
                    if (frame_tick) overrun <= 1'b1;
                    wall_hit[WALL_BOTTOM] <= bot_q;
                    wall_hit[WALL_RIGHT]  <= right_q;
                    wall_hit[WALL_TOP]    <= top_q;
                    wall_hit[WALL_LEFT]   <= left_q;
                    hit_l     <= take_l;
                    hit_r     <= take_r;
                    score_l   <= goal_l;
                    score_r   <= goal_r;
                    bounce_y  <= next_bounce;
                    dir_y     <= next_dir_y;
                    evt_valid <= 1'b1;
                    hit_zone  <= take_r ? zone_r_q : (take_l ? zone_l_q : ZONE_NONE);
                    if (take_r)      dir_x <= 1'b0;
                    else if (take_l) dir_x <= 1'b1;
                    else if (goal_r) dir_x <= 1'b0;
                    else if (goal_l) dir_x <= 1'b1;
                    if (any_hit)              lockout <= LOCK_W'(LOCK_FRAMES);
                    else if (lockout != '0)   lockout <= lockout - 1'b1;
                    if (goal_l || goal_r) begin
                        serve_cnt  <= SERVE_W'(SERVE_FRAMES);
                        serve_hold <= 1'b1;
                        state      <= ST_SERVE;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_SERVE: begin
                    if (frame_tick) begin
                        if (serve_cnt <= SERVE_W'(1)) begin
                            serve_cnt  <= '0;
                            serve_hold <= 1'b0;
                            state      <= ST_IDLE;
                        end else begin
                            serve_cnt <= serve_cnt - 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_collision_engine.sv
// Self-checking bench for collision_engine: directed frames plus randomized frames
// compared against a plain-arithmetic model of the pong collision rules.
module tb_collision_engine;

    localparam int SW = 640;
    localparam int SH = 480;
    localparam int MG = 10;
    localparam int LOCKF = 4;
    localparam int SERVEF = 60;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_tick = 1'b0;
    logic [10:0] ball_x = '0, ball_y = '0, ball_w = '0, ball_h = '0;
    logic [10:0] padl_x = '0, padl_y = '0, padl_w = '0, padl_h = '0;
    logic [10:0] padr_x = '0, padr_y = '0, padr_w = '0, padr_h = '0;
    logic [3:0]  wall_hit;
    logic        dir_x, dir_y, hit_l, hit_r, score_l, score_r, bounce_y, evt_valid;
    logic [1:0]  hit_zone;
    logic        serve_hold, overrun;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    bit m_dx = 1, m_dy = 1, m_over = 0;
    int m_lock = 0;
    logic [1:0] m_zone = 2'b00;
    int pl[4];
    int pr[4];

    collision_engine dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick),
        .ball_x(ball_x), .ball_y(ball_y), .ball_w(ball_w), .ball_h(ball_h),
        .padl_x(padl_x), .padl_y(padl_y), .padl_w(padl_w), .padl_h(padl_h),
        .padr_x(padr_x), .padr_y(padr_y), .padr_w(padr_w), .padr_h(padr_h),
        .wall_hit(wall_hit), .dir_x(dir_x), .dir_y(dir_y),
        .hit_l(hit_l), .hit_r(hit_r), .score_l(score_l), .score_r(score_r),
        .bounce_y(bounce_y), .evt_valid(evt_valid), .hit_zone(hit_zone),
        .serve_hold(serve_hold), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_paddles(input int lx, ly, lw, lh, rx, ry, rw, rh);
        pl[0] = lx; pl[1] = ly; pl[2] = lw; pl[3] = lh;
        pr[0] = rx; pr[1] = ry; pr[2] = rw; pr[3] = rh;
        padl_x = 11'(lx); padl_y = 11'(ly); padl_w = 11'(lw); padl_h = 11'(lh);
        padr_x = 11'(rx); padr_y = 11'(ry); padr_w = 11'(rw); padr_h = 11'(rh);
    endtask

    function automatic bit touches(int x, y, w, h, int p[4]);
        return (x + w >= p[0]) && (x <= p[0] + p[2]) && (y + h >= p[1]) && (y <= p[1] + p[3]);
    endfunction

    function automatic logic [1:0] zone(int c, int py, int ph);
        if (c < py + ph / 4) return 2'b01;
        if (c > py + ph - ph / 4) return 2'b11;
        return 2'b10;
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_wall"}, wall_hit, 0);
        check({tag, "_dirx"}, dir_x, 1);
        check({tag, "_diry"}, dir_y, 1);
        check({tag, "_pulses"}, {hit_l, hit_r, score_l, score_r, bounce_y, evt_valid}, 0);
        check({tag, "_zone"}, hit_zone, 0);
        check({tag, "_serve"}, serve_hold, 0);
        check({tag, "_overrun"}, overrun, 0);
    endtask

    task automatic drain_serve();
        int ticks = 0;
        int evts = 0;
        while (serve_hold === 1'b1 && ticks < SERVEF + 20) begin
            frame_tick = 1'b1;
            @(negedge clk);
            frame_tick = 1'b0;
            ticks++;
            if (evt_valid) evts++;
            @(negedge clk);
            if (evt_valid) evts++;
        end
        check("serve_ticks", ticks, SERVEF);
        check("serve_no_events", evts, 0);
        check("serve_overrun", overrun, m_over);
    endtask

    // One frame: tick (optionally held into EVAL), check latency and every output.
    task automatic run_frame(input string tag, input int x, y, w, h, input bit dbl);
        bit top, bot, lft, rgt, hr, hl, sr, sl, bnc;
        logic [3:0] exp_wall;
        top = (y <= MG);
        bot = (y + h >= SH - MG);
        lft = (x <= MG);
        rgt = (x + w >= SW - MG);
        hr  = touches(x, y, w, h, pr) && m_dx && (m_lock == 0);
        hl  = touches(x, y, w, h, pl) && !m_dx && (m_lock == 0);
        sr  = lft && !hr && !hl;
        sl  = rgt && !hr && !hl && !lft;
        exp_wall = {lft, top, rgt, bot};
        bnc = 0;
        if (top && !bot && !m_dy) begin m_dy = 1; bnc = 1; end
        else if (bot && !top && m_dy) begin m_dy = 0; bnc = 1; end
        if (hr)      m_zone = zone(y + h / 2, pr[1], pr[3]);
        else if (hl) m_zone = zone(y + h / 2, pl[1], pl[3]);
        else         m_zone = 2'b00;
        if (hr)      m_dx = 0;
        else if (hl) m_dx = 1;
        else if (sr) m_dx = 0;
        else if (sl) m_dx = 1;
        if (hr || hl)        m_lock = LOCKF;
        else if (m_lock > 0) m_lock--;
        if (dbl) m_over = 1;

        @(negedge clk);
        ball_x = 11'(x); ball_y = 11'(y); ball_w = 11'(w); ball_h = 11'(h);
        frame_tick = 1'b1;
        @(negedge clk);
        if (!dbl) frame_tick = 1'b0;
        check({tag, "_evt_c1"}, evt_valid, 0);
        @(negedge clk);
        frame_tick = 1'b0;
        check({tag, "_evt_c2"}, evt_valid, 0);
        @(negedge clk);
        check({tag, "_evt_c3"}, evt_valid, 1);
        check({tag, "_wall"}, wall_hit, exp_wall);
        check({tag, "_hits"}, {hit_l, hit_r}, {hl, hr});
        check({tag, "_scores"}, {score_l, score_r}, {sl, sr});
        check({tag, "_bounce"}, bounce_y, bnc);
        check({tag, "_dir"}, {dir_x, dir_y}, {m_dx, m_dy});
        check({tag, "_zone"}, hit_zone, m_zone);
        check({tag, "_serve"}, serve_hold, sr || sl);
        check({tag, "_overrun"}, overrun, m_over);
        @(negedge clk);
        check({tag, "_evt_width"}, evt_valid, 0);
        if (sr || sl) drain_serve();
    endtask

    initial begin
        set_paddles(20, 180, 8, 60, 620, 180, 8, 60);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset_values("reset");

        // Right-paddle hit in the middle band, then lockout mirrored on the left paddle
        run_frame("hit_r", 612, 200, 10, 10, 0);
        set_paddles(610, 180, 8, 60, 620, 180, 8, 60);
        for (int i = 0; i < 4; i++) run_frame("locked", 612, 200, 10, 10, 0);
        run_frame("unlocked", 612, 200, 10, 10, 0);
        set_paddles(20, 180, 8, 60, 620, 180, 8, 60);

        // Vertical reflection only when heading into the wall
        run_frame("bounce_bot", 300, 470, 10, 10, 0);
        run_frame("bounce_top", 300, 8, 10, 10, 0);
        run_frame("no_bounce_top", 300, 8, 10, 10, 0);

        run_frame("overrun", 300, 200, 10, 10, 1);

        // Left-wall score with no paddle contact, followed by the serve hold
        run_frame("score_r", 5, 300, 10, 10, 0);

        for (int i = 0; i < 40; i++) begin
            int x, y, w, h;
            w = $urandom_range(2, 20);
            h = $urandom_range(2, 20);
            case ($urandom_range(0, 2))
                0: begin x = $urandom_range(600, 625); y = $urandom_range(160, 250); end
                1: begin x = $urandom_range(0, 30);    y = $urandom_range(160, 250); end
                default: begin x = $urandom_range(0, 620); y = $urandom_range(0, 470); end
            endcase
            run_frame("rand", x, y, w, h, ($urandom_range(0, 7) == 0));
        end

        // Reset landing in RESOLVE must suppress the pending event
        @(negedge clk);
        ball_x = 11'd612; ball_y = 11'd200; ball_w = 11'd10; ball_h = 11'd10;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_values("rst_resolve");
        @(negedge clk);
        check("rst_resolve_after", {hit_r, evt_valid}, 0);
        m_dx = 1; m_dy = 1; m_lock = 0; m_over = 0; m_zone = 2'b00;
        run_frame("post_reset", 612, 200, 10, 10, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL timeout: observed no finish expected finish");
        $fatal(1, "[TB] timeout");
    end

endmodule
